heap_ctrl: RTL and testbench

HEAP_CTRL -- requirements
Module: heap_ctrl

---
 rtl/heap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_heap_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_ctrl.sv
// Root controller for a pipelined sort-node heap: holds the root record, sinks new
// records into level 1 and returns the evicted root through a valid/ready result port.
module heap_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           KEY_WIDTH  = 16,
  parameter int unsigned           LEVELS     = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA  = {2'b01, {(DATA_WIDTH-2){1'b0}}}
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_code,
  input  logic [DATA_WIDTH-1:0] op_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_empty,
  output logic                  node_init,
  output logic                  node_update,
  output logic [LEVELS-1:0]     node_addr,
  output logic                  node_branch,
  output logic [DATA_WIDTH-1:0] node_data,
  input  logic                  node_root_valid,
  input  logic [DATA_WIDTH-1:0] node_root_data,
  output logic                  empty,
  output logic                  busy,
  output logic                  err_no_ack
);

  if (KEY_WIDTH == 0 || KEY_WIDTH > DATA_WIDTH - 2) begin : g_key_check
    $error("heap_ctrl: KEY_WIDTH must fit below the two flag bits");
  end

  localparam int unsigned     CntW       = LEVELS + 2;
  localparam logic [CntW-1:0] WaitCycles = CntW'((1 << LEVELS) + 2);

  localparam logic [1:0] OpNop     = 2'b00;
  localparam logic [1:0] OpReplace = 2'b01;
  localparam logic [1:0] OpPop     = 2'b10;
  localparam logic [1:0] OpInit    = 2'b11;

  typedef enum logic [2:0] {
    StInit,
    StInitWait,
    StIdle,
    StIssue,
    StCapture
  } state_e;

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] root_q, root_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_empty_q, res_empty_d;
  logic [DATA_WIDTH-1:0] node_data_q, node_data_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  root_is_min;

  assign root_is_min = (root_q[DATA_WIDTH-1 -: 2] == 2'b01);
  assign op_ready    = (state_q == StIdle) && (!res_valid_q || res_ready);
  assign accept      = op_valid && op_ready;

  always_comb begin
    state_d     = state_q;
    // Held low through reset so the INIT state only pulses node_init once a clock has run.
    armed_d     = 1'b1;
    cnt_d       = cnt_q;
    root_d      = root_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_empty_d = res_empty_q;
    node_data_d = node_data_q;
    err_d       = err_q;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    unique case (state_q)
      StInit: begin
        if (armed_q) begin
          cnt_d   = WaitCycles;
          root_d  = INIT_DATA;
          err_d   = 1'b0;
          state_d = StInitWait;
        end
      end
      StInitWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (accept) begin
          unique case (op_code)
            OpNop: ;
            OpReplace, OpPop: begin
              res_valid_d = 1'b1;
              res_data_d  = root_q;
              res_empty_d = root_is_min;
              node_data_d = (op_code == OpReplace) ? op_data : INIT_DATA;
              state_d     = StIssue;
            end
            OpInit: state_d = StInit;
            default: ;
          endcase
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        if (node_root_valid) begin
          root_d = node_root_data;
        end else begin
          err_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StInit;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      root_q      <= INIT_DATA;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_empty_q <= 1'b0;
      node_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      root_q      <= root_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_empty_q <= res_empty_d;
      node_data_q <= node_data_d;
      err_q       <= err_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_empty   = res_empty_q;
  assign node_init   = (state_q == StInit) && armed_q;
  assign node_update = (state_q == StIssue);
  assign node_addr   = '0;
  assign node_branch = 1'b0;
  assign node_data   = node_data_q;
  assign empty       = root_is_min;
  assign busy        = (state_q != StIdle);
  assign err_no_ack  = err_q;

endmodule

// File: tb/tb_heap_ctrl.sv
// Bench for heap_ctrl: a transaction-level model tracks root and error flag; the bench
// plays the level-1 node, answering each update pulse with a chosen root value.
module tb_heap_ctrl;
  localparam int unsigned DW     = 32;
  localparam int unsigned LEVELS = 4;
  localparam logic [DW-1:0] INIT = 32'h4000_0000;
  localparam int          W      = (1 << LEVELS) + 2;
  localparam logic [1:0] NOP = 2'b00, REPL = 2'b01, POP = 2'b10, INI = 2'b11;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [1:0]    op_code = 2'b00;
  logic [DW-1:0] op_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic          res_empty;
  logic          node_init;
  logic          node_update;
  logic [LEVELS-1:0] node_addr;
  logic          node_branch;
  logic [DW-1:0] node_data;
  logic          node_root_valid = 1'b0;
  logic [DW-1:0] node_root_data = '0;
  logic          empty;
  logic          busy;
  logic          err_no_ack;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] m_root = INIT;
  logic          m_err  = 1'b0;

  heap_ctrl #(.DATA_WIDTH(DW), .KEY_WIDTH(16), .LEVELS(LEVELS), .INIT_DATA(INIT)) dut (
    .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_data(op_data), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_empty(res_empty), .node_init(node_init), .node_update(node_update),
    .node_addr(node_addr), .node_branch(node_branch), .node_data(node_data),
    .node_root_valid(node_root_valid), .node_root_data(node_root_data), .empty(empty),
    .busy(busy), .err_no_ack(err_no_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic is_min(input logic [DW-1:0] v);
    return v[DW-1:DW-2] == 2'b01;
  endfunction

  task automatic check_reset_values(input string tag);
    checks++;
    if ({node_init, node_update, op_ready, res_valid, res_empty, err_no_ack} !== 6'b0) begin
      errors++;
      $display("FAIL %s ctrl: init=%b upd=%b rdy=%b rv=%b re=%b err=%b, all required 0", tag,
               node_init, node_update, op_ready, res_valid, res_empty, err_no_ack);
    end
    checks++;
    if (res_data !== '0 || node_data !== '0) begin
      errors++;
      $display("FAIL %s data: res_data=%h node_data=%h, required 0", tag, res_data, node_data);
    end
    checks++;
    if (empty !== 1'b1 || busy !== 1'b1 || node_addr !== '0 || node_branch !== 1'b0) begin
      errors++;
      $display("FAIL %s status: empty=%b busy=%b addr=%h br=%b, required 1 1 0 0", tag,
               empty, busy, node_addr, node_branch);
    end
  endtask

  // Called at the negedge of cycle 0 (first cycle with node_init expected high).
  task automatic check_init_seq(input string tag);
    for (int c = 0; c <= W + 2; c++) begin
      checks++;
      if (node_init !== (c == 0) || op_ready !== (c >= W + 1) || busy !== (c < W + 1)) begin
        errors++;
        $display("FAIL %s cycle %0d: init=%b rdy=%b busy=%b, required %b %b %b", tag, c,
                 node_init, op_ready, busy, c == 0, c >= W + 1, c < W + 1);
      end
      if (c >= 1) begin
        checks++;
        if (empty !== 1'b1 || res_valid !== 1'b0 || err_no_ack !== 1'b0) begin
          errors++;
          $display("FAIL %s cycle %0d: empty=%b rv=%b err=%b, required 1 0 0", tag, c,
                   empty, res_valid, err_no_ack);
        end
      end
      if (c < W + 2) tick();
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!op_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: op_ready=%b, required 1", tag, op_ready);
    end
  endtask

  // One NOP/REPLACE/POP with res_ready held at its current value.
  task automatic do_op(input string tag, input logic [1:0] code, input logic [DW-1:0] data,
                       input logic [DW-1:0] ret, input logic ack, input logic glitch);
    logic hold;
    logic [DW-1:0] exp_nd;
    hold = !res_ready;
    wait_ready(tag);
    op_valid = 1'b1;
    op_code  = code;
    op_data  = data;
    tick();
    op_valid = 1'b0;
    if (code == NOP) begin
      checks++;
      if (busy !== 1'b0 || op_ready !== 1'b1 || res_valid !== 1'b0 || node_update !== 1'b0) begin
        errors++;
        $display("FAIL %s nop: busy=%b rdy=%b rv=%b upd=%b, required 0 1 0 0", tag, busy,
                 op_ready, res_valid, node_update);
      end
      return;
    end
    exp_nd = (code == REPL) ? data : INIT;
    checks++;
    if (node_update !== 1'b1 || node_data !== exp_nd || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s issue: upd=%b node_data=%h busy=%b, required 1 %h 1", tag,
               node_update, node_data, busy, exp_nd);
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== m_root || res_empty !== is_min(m_root)) begin
      errors++;
      $display("FAIL %s result: rv=%b data=%h re=%b, required 1 %h %b", tag, res_valid,
               res_data, res_empty, m_root, is_min(m_root));
    end
    if (glitch) begin
      node_root_valid = 1'b1;
      node_root_data  = ~ret;
    end
    tick();
    node_root_valid = ack;
    node_root_data  = ret;
    checks++;
    if (node_update !== 1'b0 || res_valid !== hold || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s capture: upd=%b rv=%b rdy=%b, required 0 %b 0", tag, node_update,
               res_valid, op_ready, hold);
    end
    tick();
    node_root_valid = 1'b0;
    if (ack) m_root = ret;
    else m_err = 1'b1;
    checks++;
    if (busy !== 1'b0 || empty !== is_min(m_root) || err_no_ack !== m_err) begin
      errors++;
      $display("FAIL %s after: busy=%b empty=%b err=%b, required 0 %b %b", tag, busy, empty,
               err_no_ack, is_min(m_root), m_err);
    end
  endtask

  task automatic do_init(input string tag);
    wait_ready(tag);
    op_valid = 1'b1;
    op_code  = INI;
    tick();
    op_valid = 1'b0;
    m_root = INIT;
    m_err  = 1'b0;
    check_init_seq(tag);
  endtask

  task automatic test_reset();
    tick();
    tick();
    check_reset_values("reset");
    rstn = 1'b1;
    tick();
    check_init_seq("reset_release");
  endtask

  task automatic test_pop_empty();
    do_op("pop_empty", POP, 32'h0, INIT, 1'b1, 1'b0);
  endtask

  task automatic test_replace_pop();
    do_op("replace5", REPL, 32'h5, 32'h5, 1'b1, 1'b0);
    do_op("pop5", POP, 32'h0, INIT, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    held = m_root;
    res_ready = 1'b0;
    do_op("bp_replace", REPL, 32'h0000_0abc, 32'h0000_0abc, 1'b1, 1'b0);
    op_valid = 1'b1;
    op_code  = POP;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (op_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== held ||
          res_empty !== is_min(held) || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold %0d: rdy=%b rv=%b data=%h re=%b busy=%b, required 0 1 %h %b 0",
                 i, op_ready, res_valid, res_data, res_empty, busy, held, is_min(held));
      end
      tick();
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: op_ready=%b, required 1", op_ready);
    end
    tick();
    op_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== m_root || node_update !== 1'b1 ||
        node_data !== INIT) begin
      errors++;
      $display("FAIL bp_chain: rv=%b data=%h upd=%b nd=%h, required 1 %h 1 %h", res_valid,
               res_data, node_update, node_data, m_root, INIT);
    end
    tick();
    node_root_valid = 1'b1;
    node_root_data  = INIT;
    tick();
    node_root_valid = 1'b0;
    m_root = INIT;
    checks++;
    if (empty !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: empty=%b rv=%b busy=%b, required 1 0 0", empty, res_valid, busy);
    end
  endtask

  task automatic test_no_ack();
    do_op("seed", REPL, 32'h0000_0077, 32'h0000_0077, 1'b1, 1'b0);
    do_op("no_ack", REPL, 32'h0000_0123, 32'h0000_0999, 1'b0, 1'b0);
    do_op("after_no_ack", POP, 32'h0, 32'h0000_0042, 1'b1, 1'b0);
    do_init("init_op");
    do_op("pop_after_init", POP, 32'h0, INIT, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      logic [DW-1:0] d, r;
      sel = $urandom_range(0, 19);
      d = $urandom();
      r = $urandom();
      if (sel == 0) do_init("rnd_init");
      else if (sel < 4) do_op("rnd_nop", NOP, d, r, 1'b1, 1'b0);
      else do_op((sel[0]) ? "rnd_replace" : "rnd_pop", (sel[0]) ? REPL : POP, d, r,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_reset_mid();
    do_op("pre_mid", REPL, 32'h0000_0010, 32'h0000_0010, 1'b1, 1'b0);
    wait_ready("mid");
    op_valid = 1'b1;
    op_code  = POP;
    tick();
    op_valid = 1'b0;
    tick();
    node_root_valid = 1'b1;
    node_root_data  = 32'h0000_0bad;
    rstn = 1'b0;
    #1;
    check_reset_values("reset_mid");
    tick();
    node_root_valid = 1'b0;
    check_reset_values("reset_mid_held");
    rstn = 1'b1;
    m_root = INIT;
    m_err  = 1'b0;
    tick();
    check_init_seq("reset_mid_release");
    do_op("pop_after_mid", POP, 32'h0, INIT, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pop_empty();
    test_replace_pop();
    test_backpressure();
    test_no_ack();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
